// File: rtl/switch_debouncer.sv
// switch_debouncer: per-bit level debouncer array for noisy mechanical switches
`timescale 1ns/100ps

module debouncer #(
  parameter int DELAY = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic in_switch,
  output logic out_switch
);
  localparam int NR = (DELAY + 1) / 2;
  localparam int N  = (NR < 1) ? 1 : NR;
  localparam int CW = ($clog2(N + 1) < 1) ? 1 : $clog2(N + 1);
  logic [CW-1:0] cnt;
  // Follow the input only after N consecutive differing samples; any match restarts the count
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_switch <= 1'b0;
      cnt        <= '0;
    end else if (in_switch == out_switch)
      cnt <= '0;
    else if (cnt == CW'(N - 1)) begin
      out_switch <= in_switch;
      cnt        <= '0;
    end else
      cnt <= cnt + 1'b1;
endmodule

module switch_debouncer #(
  parameter int DELAY = 5,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_switch,
  output logic [WIDTH-1:0] out_switch
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debouncer #(.DELAY(DELAY)) u_deb (
      .clk        (clk),
      .rst        (rst),
      .in_switch  (in_switch[i]),
      .out_switch (out_switch[i])
    );
  end
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed vectors with a queue-based scoreboard for a 5-bit debouncer array
`timescale 1ns/100ps

module tb_switch_debouncer;
  typedef struct {
    int         idx;
    logic [4:0] pre;
    logic [4:0] post;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] in_switch = '0;
  logic [4:0] out_switch;
  exp_t       q[$];
  int         checks = 0;
  int         fails = 0;
  int         vec_n = 0;

  switch_debouncer #(.DELAY(5), .WIDTH(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_switch  (in_switch),
    .out_switch (out_switch)
  );

  initial forever #1 clk = ~clk;

  function automatic void chk(string nm, int idx, logic [4:0] act, logic [4:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s vec %0d: out_switch=%b expected %b at %0t", nm, idx, act, req, $time);
    end
  endfunction

  // pre: expected output just after driving (before the edge); post: expected after the next rising edge
  task automatic vec(input logic r, input logic [4:0] i, input logic [4:0] pre, input logic [4:0] post, input int reps);
    for (int k = 0; k < reps; k++) begin
      @(negedge clk);
      rst       = r;
      in_switch = i;
      q.push_back('{vec_n, pre, post});
    end
    vec_n++;
  endtask

  // Monitor: pops one expectation per cycle and checks both sample points
  initial forever begin
    exp_t e;
    @(negedge clk);
    #0.5;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("pre_edge", e.idx, out_switch, e.pre);
      @(posedge clk);
      #0.5;
      chk("post_edge", e.idx, out_switch, e.post);
    end
  end

  initial begin
    vec(1, 5'h1F, 5'h00, 5'h00, 3);
    vec(0, 5'h1F, 5'h00, 5'h00, 2);
    vec(0, 5'h00, 5'h00, 5'h00, 3);
    vec(0, 5'h1F, 5'h00, 5'h00, 2);
    vec(0, 5'h1F, 5'h00, 5'h1F, 1);
    vec(0, 5'h1F, 5'h1F, 5'h1F, 2);
    vec(0, 5'h00, 5'h1F, 5'h1F, 2);
    vec(0, 5'h00, 5'h1F, 5'h00, 1);
    vec(0, 5'h00, 5'h00, 5'h00, 11);
    vec(0, 5'h01, 5'h00, 5'h00, 2);
    vec(0, 5'h00, 5'h00, 5'h00, 3);
    vec(0, 5'h1F, 5'h00, 5'h00, 2);
    vec(0, 5'h00, 5'h00, 5'h00, 1);
    vec(0, 5'h1F, 5'h00, 5'h00, 2);
    vec(0, 5'h1F, 5'h00, 5'h1F, 1);
    vec(0, 5'h1F, 5'h1F, 5'h1F, 1);
    vec(1, 5'h1F, 5'h00, 5'h00, 2);
    vec(0, 5'h1F, 5'h00, 5'h00, 2);
    vec(1, 5'h1F, 5'h00, 5'h00, 1);
    vec(0, 5'h1F, 5'h00, 5'h00, 2);
    vec(0, 5'h1F, 5'h00, 5'h1F, 1);
    vec(0, 5'h1F, 5'h1F, 5'h1F, 2);
    @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
